// File: rtl/srff_checker.sv
// Cycle-accurate response checker for an SR flip-flop with async preset/clear.
// Tracks a reference model, compares q/qbar each edge and keeps saturating statistics.
module srff_checker #(
    parameter int CW          = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          s,
    input  logic          r,
    input  logic          preset,
    input  logic          clear,
    input  logic          q,
    input  logic          qbar,
    output logic          err,
    output logic [CW-1:0] err_count,
    output logic [CW-1:0] chk_count,
    output logic [CW-1:0] ill_count,
    output logic [CW-1:0] first_err,
    output logic [1:0]    state
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SYNC  = 2'b01;
    localparam logic [1:0] ST_CHECK = 2'b10;
    localparam logic [1:0] ST_FAIL  = 2'b11;

    logic [1:0]    r_state;
    logic          r_exp_q;
    logic          r_known;
    logic          r_err;
    logic [CW-1:0] r_err_cnt;
    logic [CW-1:0] r_chk_cnt;
    logic [CW-1:0] r_ill_cnt;
    logic [CW-1:0] r_first_err;

    logic          w_exp_q_nxt;
    logic          w_known_nxt;
    logic          w_expect;
    logic          w_cmp;
    logic          w_mismatch;
    logic          w_illegal;
    logic          w_active;
    logic [1:0]    w_state_nxt;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Reference model next state: clear beats preset beats the SR inputs.
    always_comb begin
        w_exp_q_nxt = r_exp_q;
        w_known_nxt = r_known;
        if (clear) begin
            w_exp_q_nxt = 1'b0;
            w_known_nxt = 1'b1;
        end else if (preset) begin
            w_exp_q_nxt = 1'b1;
            w_known_nxt = 1'b1;
        end else begin
            case ({s, r})
                2'b10:   w_exp_q_nxt = 1'b1;
                2'b01:   w_exp_q_nxt = 1'b0;
                2'b11:   w_known_nxt = 1'b0;
                default: w_exp_q_nxt = r_exp_q;
            endcase
        end
    end

    // Async controls force q between edges, so they override the registered model.
    assign w_expect   = clear ? 1'b0 : (preset ? 1'b1 : r_exp_q);
    assign w_illegal  = s & r;
    assign w_active   = en && (r_state != ST_FAIL);
    assign w_cmp      = en && (r_state == ST_CHECK);
    assign w_mismatch = w_cmp && ((r_known && (q != w_expect)) || (qbar == q));

    // A CHECK cycle with known already low is still compared (qbar only) before returning to SYNC.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (en) w_state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
                if (!en)              w_state_nxt = ST_IDLE;
                else if (w_known_nxt) w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (!en)                            w_state_nxt = ST_IDLE;
                else if (STOP_ON_ERR && w_mismatch) w_state_nxt = ST_FAIL;
                else if (!r_known)                  w_state_nxt = ST_SYNC;
            end
            default: w_state_nxt = ST_FAIL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_exp_q     <= 1'b0;
            r_known     <= 1'b0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
            r_chk_cnt   <= '0;
            r_ill_cnt   <= '0;
            r_first_err <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_exp_q <= w_exp_q_nxt;
            r_known <= w_known_nxt;
            r_err   <= w_mismatch;
            if (w_cmp) r_chk_cnt <= sat_inc(r_chk_cnt);
            if (w_active && w_illegal) r_ill_cnt <= sat_inc(r_ill_cnt);
            if (w_mismatch) begin
                r_err_cnt <= sat_inc(r_err_cnt);
                if (r_err_cnt == '0) r_first_err <= r_chk_cnt;
            end
        end
    end

    assign err       = r_err;
    assign err_count = r_err_cnt;
    assign chk_count = r_chk_cnt;
    assign ill_count = r_ill_cnt;
    assign first_err = r_first_err;
    assign state     = r_state;

endmodule

// File: tb/tb_srff_checker.sv
// Directed bench for srff_checker: vector table plus hand-written multi-cycle sequences.
module tb_srff_checker;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en = 1'b0, s = 1'b0, r = 1'b0, preset = 1'b0, clear = 1'b0;
    logic q_drv = 1'b0, qb_drv = 1'b1, use_model = 1'b0;
    logic m_ff = 1'b0;
    logic m_q, q, qbar;

    logic        err0, err1, err4;
    logic [15:0] errc0, chk0, ill0, first0;
    logic [15:0] errc1, chk1, ill1, first1;
    logic [3:0]  errc4, chk4, ill4, first4;
    logic [1:0]  st0, st1, st4;

    int n_vec  = 0;
    int n_fail = 0;

    always #10 clk = ~clk;

    // Behavioural flip-flop under observation (used only for the free-running toggle test).
    always @(posedge clk or negedge reset) begin
        if (!reset)          m_ff <= 1'b0;
        else if (clear)      m_ff <= 1'b0;
        else if (preset)     m_ff <= 1'b1;
        else if (s && !r)    m_ff <= 1'b1;
        else if (!s && r)    m_ff <= 1'b0;
    end
    assign m_q  = clear ? 1'b0 : (preset ? 1'b1 : m_ff);
    assign q    = use_model ? m_q : q_drv;
    assign qbar = use_model ? ~m_q : qb_drv;

    srff_checker #(.CW(16), .STOP_ON_ERR(1'b0)) dut (
        .clk(clk), .reset(reset), .en(en), .s(s), .r(r), .preset(preset), .clear(clear),
        .q(q), .qbar(qbar), .err(err0), .err_count(errc0), .chk_count(chk0),
        .ill_count(ill0), .first_err(first0), .state(st0));

    srff_checker #(.CW(16), .STOP_ON_ERR(1'b1)) dut_stop (
        .clk(clk), .reset(reset), .en(en), .s(s), .r(r), .preset(preset), .clear(clear),
        .q(q), .qbar(qbar), .err(err1), .err_count(errc1), .chk_count(chk1),
        .ill_count(ill1), .first_err(first1), .state(st1));

    srff_checker #(.CW(4), .STOP_ON_ERR(1'b0)) dut4 (
        .clk(clk), .reset(reset), .en(en), .s(s), .r(r), .preset(preset), .clear(clear),
        .q(q), .qbar(qbar), .err(err4), .err_count(errc4), .chk_count(chk4),
        .ill_count(ill4), .first_err(first4), .state(st4));

    typedef struct {
        logic       en, s, r, p, c, q, qb;
        logic       x_err;
        logic [1:0] x_state;
        int         x_chk, x_errc, x_first;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic ven, input logic vs, input logic vr, input logic vp,
                        input logic vc, input logic vq, input logic vqb);
        @(negedge clk);
        en = ven; s = vs; r = vr; preset = vp; clear = vc; q_drv = vq; qb_drv = vqb;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; en = 1'b0; s = 1'b0; r = 1'b0; preset = 1'b0; clear = 1'b0;
        q_drv = 1'b0; qb_drv = 1'b1; use_model = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_delta, err_pulses;
        logic [15:0] prev_c;
        logic [1:0]  prev_st;

        //            en s  r  p  c  q  qb  err st     chk errc first
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 1, 0, 2'b01, 0,  0, 0};
        tbl[1]  = '{1, 0, 0, 0, 1, 0, 1, 0, 2'b10, 0,  0, 0};
        tbl[2]  = '{1, 0, 0, 0, 0, 0, 1, 0, 2'b10, 1,  0, 0};
        tbl[3]  = '{1, 1, 0, 0, 0, 0, 1, 0, 2'b10, 2,  0, 0};
        tbl[4]  = '{1, 0, 1, 0, 0, 1, 0, 0, 2'b10, 3,  0, 0};
        tbl[5]  = '{1, 0, 0, 0, 0, 0, 1, 0, 2'b10, 4,  0, 0};
        tbl[6]  = '{1, 0, 0, 0, 0, 0, 1, 0, 2'b10, 5,  0, 0};
        tbl[7]  = '{1, 0, 0, 1, 0, 1, 0, 0, 2'b10, 6,  0, 0};
        tbl[8]  = '{1, 0, 0, 0, 0, 1, 0, 0, 2'b10, 7,  0, 0};
        tbl[9]  = '{1, 0, 0, 1, 1, 0, 1, 0, 2'b10, 8,  0, 0};
        tbl[10] = '{1, 0, 0, 0, 0, 1, 0, 1, 2'b10, 9,  1, 8};
        tbl[11] = '{1, 0, 0, 0, 0, 0, 1, 0, 2'b10, 10, 1, 8};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 10, 1, 8};
        tbl[13] = '{1, 0, 0, 0, 0, 0, 1, 0, 2'b01, 10, 1, 8};
        tbl[14] = '{1, 0, 0, 0, 0, 0, 1, 0, 2'b10, 10, 1, 8};
        tbl[15] = '{1, 0, 0, 0, 0, 0, 1, 0, 2'b10, 11, 1, 8};

        do_reset();
        check("rst_state", st0, 0);
        check("rst_err", err0, 0);
        check("rst_errc", errc0, 0);
        check("rst_chk", chk0, 0);
        check("rst_ill", ill0, 0);
        check("rst_first", first0, 0);

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].en, tbl[i].s, tbl[i].r, tbl[i].p, tbl[i].c, tbl[i].q, tbl[i].qb);
            check($sformatf("tbl%0d_err", i), err0, tbl[i].x_err);
            check($sformatf("tbl%0d_state", i), st0, tbl[i].x_state);
            check($sformatf("tbl%0d_chk", i), chk0, tbl[i].x_chk);
            check($sformatf("tbl%0d_errc", i), errc0, tbl[i].x_errc);
            check($sformatf("tbl%0d_first", i), first0, tbl[i].x_first);
        end
        check("tbl_ill", ill0, 0);

        // s=r=1 for three cycles while checking, then clear to resynchronise.
        do_reset();
        step(1, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 0, 1);
        check("ill_state_sync", st0, 2'b01);
        check("ill_count3", ill0, 3);
        check("ill_no_err", errc0, 0);
        step(1, 0, 0, 0, 1, 0, 1);
        check("ill_back_check", st0, 2'b10);
        step(1, 0, 0, 0, 0, 0, 1);
        check("ill_chk", chk0, 4);
        check("ill_err_after", err0, 0);

        // qbar stuck equal to q: every compared cycle errs, including one with known=0.
        do_reset();
        step(1, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0);
        check("qb_err_a", err0, 1);
        step(1, 1, 1, 0, 0, 0, 0);
        check("qb_err_b", err0, 1);
        step(1, 1, 1, 0, 0, 0, 0);
        check("qb_err_unknown", err0, 1);
        check("qb_state", st0, 2'b01);
        check("qb_errc", errc0, 3);

        // q stuck at 0; set at chk_count=4 so the mismatch lands on compare 5.
        do_reset();
        step(1, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, 1);
        check("stuck_pre_err", err0, 0);
        step(1, 0, 1, 0, 0, 0, 1);
        check("stuck_err", err0, 1);
        check("stuck_errc", errc0, 1);
        check("stuck_first", first0, 5);
        check("stop_state", st1, 2'b11);
        check("stop_err", err1, 1);
        check("stop_first", first1, 5);
        step(1, 0, 0, 0, 0, 0, 1);
        check("stuck_err_once", err0, 0);
        check("stuck_chk", chk0, 7);
        step(1, 1, 0, 0, 0, 0, 1);
        step(1, 1, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        check("stuck_errc2", errc0, 2);
        check("stop_err_zero", err1, 0);
        check("stop_chk_frozen", chk1, 6);
        check("stop_errc_frozen", errc1, 1);
        check("stop_ill_frozen", ill1, 0);
        check("stop_state_held", st1, 2'b11);

        // CW=4 saturation with a permanently failing qbar, then async reset mid-run.
        do_reset();
        step(1, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 40; i++) step(1, 0, 0, 0, 0, 0, 0);
        check("sat_errc", errc4, 15);
        check("sat_chk", chk4, 15);
        check("sat_err", err4, 1);
        check("sat_state", st4, 2'b10);
        check("wide_chk", chk0, 40);
        @(negedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("arst_errc", errc4, 0);
        check("arst_chk", chk4, 0);
        check("arst_err", err4, 0);
        check("arst_state", st4, 0);
        check("arst_ill", ill4, 0);
        check("arst_first", first4, 0);

        // Correct flip-flop under the free-running toggle stimulus.
        do_reset();
        use_model = 1'b1;
        en = 1'b1;
        bad_delta = 0;
        err_pulses = 0;
        @(posedge clk);
        #3;
        fork
            repeat (100) begin #20; s = ~s; end
            repeat (66)  begin #30; r = ~r; end
            repeat (50)  begin #40; preset = ~preset; end
            repeat (40)  begin #50; clear = ~clear; end
            repeat (99) begin
                prev_c  = chk0;
                prev_st = st0;
                @(posedge clk);
                #1;
                if (chk0 - prev_c != ((prev_st == 2'b10) ? 16'd1 : 16'd0)) bad_delta++;
                if (err0) err_pulses++;
            end
        join
        check("tog_errc", errc0, 0);
        check("tog_err_pulses", err_pulses, 0);
        check("tog_chk_step", bad_delta, 0);
        check("tog_ill_seen", (ill0 > 0) ? 1 : 0, 1);
        check("tog_chk_seen", (chk0 > 40) ? 1 : 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
